// File: rtl/led_strip_sched_if.sv
// Bus bundle for led_strip_sched: APB3 register port plus the pixel stream to the
// bit-level LED encoder and the frame status lines.
interface led_strip_sched_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        frame_done;

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, pix_ready,
      output PRDATA, PREADY, PSLVERR, pix_data, pix_valid, pix_last, busy, frame_done
   );

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, pix_ready,
      input  PRDATA, PREADY, PSLVERR, pix_data, pix_valid, pix_last, busy, frame_done
   );
endinterface

// File: rtl/led_strip_sched.sv
// LED strip frame scheduler: double-buffered pixel colours behind an APB3 slave,
// streamed pixel by pixel into the encoder, followed by a timed latch gap.
module led_strip_sched #(
   parameter int NUM_LEDS     = 15,
   parameter int RESET_CYCLES = 50000,
   parameter int SLOT         = 8
) (
   input logic              PCLK,
   input logic              PRESET,
   led_strip_sched_if.slave bus
);
   localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;
   state_t state, state_nxt;

   logic          enable, auto_repeat, pending, aborted;
   logic [7:0]    frame_cnt;
   logic [IW-1:0] idx;
   logic [CW-1:0] gap_cnt;
   logic [23:0]   staging [NUM_LEDS];
   logic [23:0]   active  [NUM_LEDS];

   logic       slot_hit, wr, rd, ctrl_sel, stat_sel, pix_sel;
   logic       ctrl_wr, start_wr, en_eff, busy, accept;
   logic [5:0] off, pix_off;
   logic       load, adv, abort, enter_latch, send, done;
   logic [31:0] rdata;

   assign slot_hit = (bus.PADDR[11:8] == 4'(SLOT));
   assign off      = bus.PADDR[7:2];
   assign wr       = bus.PSEL & bus.PENABLE & bus.PWRITE & slot_hit;
   assign rd       = bus.PSEL & ~bus.PWRITE & slot_hit;
   assign ctrl_sel = (off == 6'h00);
   assign stat_sel = (off == 6'h01);
   assign pix_sel  = (off >= 6'h10) && (off < 6'(16 + NUM_LEDS));
   assign pix_off  = off - 6'h10;

   // A CTRL write acts on the edge that commits it, so enable+start in one write
   // launches a frame straight from reset, and clearing enable aborts at once.
   assign ctrl_wr  = wr & ctrl_sel;
   assign start_wr = ctrl_wr & bus.PWDATA[2];
   assign en_eff   = ctrl_wr ? bus.PWDATA[0] : enable;
   assign busy     = (state != IDLE);
   assign accept   = (state == SEND) & bus.pix_ready;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      adv         = 1'b0;
      abort       = 1'b0;
      enter_latch = 1'b0;
      send        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (en_eff && (pending || start_wr)) begin
               load      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            send = 1'b1;
            if (accept && idx == LAST_IDX) begin
               enter_latch = 1'b1;
               state_nxt   = LATCH;
            end else if (!en_eff) begin
               abort       = 1'b1;
               enter_latch = 1'b1;
               state_nxt   = LATCH;
            end else if (accept) begin
               adv = 1'b1;
            end
         end
         LATCH: begin
            if (gap_cnt == GAP_END) begin
               done = ~aborted;
               if (en_eff && (pending || auto_repeat)) begin
                  load      = 1'b1;
                  state_nxt = SEND;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         enable      <= 1'b0;
         auto_repeat <= 1'b0;
         pending     <= 1'b0;
         aborted     <= 1'b0;
         frame_cnt   <= '0;
         idx         <= '0;
         gap_cnt     <= '0;
         // NOTE: both buffers are flop arrays that must read back 0 after reset, so they are cleared here; a RAM-based buffer could not be.
         for (int i = 0; i < NUM_LEDS; i++) begin
            staging[i] <= '0;
            active[i]  <= '0;
         end
      end else begin
         if (ctrl_wr) begin
            enable      <= bus.PWDATA[0];
            auto_repeat <= bus.PWDATA[1];
         end
         if (load || abort)           pending <= 1'b0;
         else if (start_wr && busy)   pending <= 1'b1;

         for (int i = 0; i < NUM_LEDS; i++)
            if (wr && pix_sel && pix_off == 6'(i)) staging[i] <= bus.PWDATA[23:0];

         if (load) begin
            // NOTE: non-blocking copy, so a staging write on this same edge is not seen by the frame being loaded.
            for (int i = 0; i < NUM_LEDS; i++) active[i] <= staging[i];
            idx <= '0;
         end else if (adv) begin
            idx <= idx + IW'(1);
         end

         if (enter_latch) begin
            gap_cnt <= '0;
            aborted <= abort;
         end else if (state == LATCH) begin
            gap_cnt <= gap_cnt + CW'(1);
         end

         if (done) frame_cnt <= frame_cnt + 8'd1;
      end
   end

   always_comb begin
      rdata = '0;
      if (rd) begin
         if (ctrl_sel)      rdata = {30'd0, auto_repeat, enable};
         else if (stat_sel) rdata = {16'd0, frame_cnt, 6'd0, pending, busy};
         else if (pix_sel)
            for (int i = 0; i < NUM_LEDS; i++)
               if (pix_off == 6'(i)) rdata = {8'd0, staging[i]};
      end
   end

   assign bus.PRDATA     = rdata;
   assign bus.PREADY     = 1'b1;
   assign bus.PSLVERR    = bus.PSEL & bus.PENABLE & slot_hit & ~(ctrl_sel | stat_sel | pix_sel);
   assign bus.pix_valid  = send;
   assign bus.pix_data   = send ? active[idx] : 24'd0;
   assign bus.pix_last   = send & (idx == LAST_IDX);
   assign bus.busy       = busy;
   assign bus.frame_done = done;
endmodule

// File: tb/tb_led_strip_sched.sv
// Directed bench for led_strip_sched: a pixel scoreboard plus latch-gap timing model
// checked every cycle, and hand-computed register/pixel expectations.
module tb_led_strip_sched;
   localparam int NL   = 15;
   localparam int RC   = 64;
   localparam int SLOT = 8;

   logic PCLK   = 1'b0;
   logic PRESET = 1'b1;
   led_strip_sched_if bus();

   led_strip_sched #(.NUM_LEDS(NL), .RESET_CYCLES(RC), .SLOT(SLOT)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed { logic [23:0] d; logic last; } px_t;
   px_t         exp_q[$];
   px_t         e;
   logic [23:0] stg [NL];
   int total = 0, bad = 0;
   int done_cnt = 0, acc_cnt = 0, frame_pos = 0, since_last = 0, stall_cnt = 0;
   int ready_mode = 0, cyc = 0;
   bit in_gap = 0, b2b = 0, expect_done = 0, stalled = 0;
   logic [23:0] held, first_px, last_px, px3_last;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] addr_of(int off);
      return {20'd0, 4'(SLOT), 6'(off), 2'b00};
   endfunction

   task automatic apb_write(int off, logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = addr_of(off); bus.PWDATA = data;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      #1 err = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic w(int off, logic [31:0] data);
      logic err;
      apb_write(off, data, err);
   endtask

   task automatic apb_read(int off, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr_of(off);
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      #1 data = bus.PRDATA; err = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic push_frame(int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{d: stg[i], last: (i == NL - 1)});
   endtask

   task automatic wait_done(int target, int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge PCLK);
         n++;
      end
      #1 check("wait_frame_done", done_cnt, target);
   endtask

   // Encoder stand-in: always ready, ready one cycle in three, stop at pixel 7, or never.
   initial begin
      bus.pix_ready = 1'b0;
      forever begin
         @(posedge PCLK); #1;
         cyc++;
         case (ready_mode)
            0:       bus.pix_ready = 1'b1;
            1:       bus.pix_ready = (cyc % 3 == 0);
            2:       bus.pix_ready = (frame_pos < 7);
            default: bus.pix_ready = 1'b0;
         endcase
      end
   end

   // Every cycle: accepted pixels against the expected stream, hold while stalled,
   // frame_done exactly RC cycles after a completed frame, and gap length when chained.
   always @(negedge PCLK) begin
      if (PRESET) begin
         in_gap = 0; stalled = 0; frame_pos = 0; expect_done = 0;
      end else begin
         if (in_gap) since_last++;
         if (bus.frame_done) begin
            check("done_expected", 32'(expect_done), 1);
            check("latch_cycles", since_last, RC);
            expect_done = 0;
            done_cnt++;
         end
         if (bus.pix_valid) begin
            if (in_gap) begin
               if (b2b) check("frame_gap", since_last - 1, RC);
               in_gap = 0;
            end
            check("busy_while_valid", 32'(bus.busy), 1);
            if (stalled) begin
               check("stall_hold", bus.pix_data, held);
               stall_cnt++;
            end
            if (bus.pix_ready) begin
               stalled = 0;
               check("px_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("px_data", bus.pix_data, e.d);
                  check("px_last", 32'(bus.pix_last), 32'(e.last));
                  if (frame_pos == 0) first_px = bus.pix_data;
                  if (frame_pos == 3) px3_last = bus.pix_data;
                  last_px = bus.pix_data;
                  acc_cnt++;
                  frame_pos++;
                  if (e.last) begin
                     frame_pos = 0; in_gap = 1; since_last = 0; expect_done = 1;
                  end
               end
            end else begin
               stalled = 1;
               held    = bus.pix_data;
            end
         end else begin
            stalled   = 0;
            frame_pos = 0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdv;
      logic        err;
      int          acc0, n;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      for (int i = 0; i < NL; i++) stg[i] = '0;

      // Reset state
      repeat (3) @(posedge PCLK);
      #2;
      check("rst_pix_valid", 32'(bus.pix_valid), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_pready", 32'(bus.PREADY), 1);
      check("rst_frame_done", 32'(bus.frame_done), 0);
      check("rst_pix_data", bus.pix_data, 0);
      @(posedge PCLK); #1 PRESET = 1'b0;
      apb_read(1, rdv, err);
      check("status_after_reset", rdv, 32'h0);
      check("status_no_err", 32'(err), 0);

      // Single-shot frame
      for (int i = 0; i < NL; i++) begin
         stg[i] = 24'h010000 + 24'(i);
         w(16 + i, 32'h010000 + 32'(i));
      end
      push_frame(NL);
      acc0 = acc_cnt;
      w(0, 32'h5);
      wait_done(1, NL + RC + 50);
      check("t1_accepts", acc_cnt - acc0, 15);
      check("t1_first_px", first_px, 24'h010000);
      check("t1_last_px", last_px, 24'h01000E);
      repeat (2) @(posedge PCLK);
      apb_read(1, rdv, err);
      check("t1_status", rdv, 32'h0000_0100);

      // Backpressure
      ready_mode = 1;
      acc0 = acc_cnt;
      push_frame(NL);
      w(0, 32'h5);
      wait_done(2, 3 * NL + RC + 100);
      check("t2_accepts", acc_cnt - acc0, 15);
      check("t2_stalls_seen", 32'(stall_cnt > 0), 1);
      ready_mode = 0;

      // Double buffering and collapsed starts
      push_frame(NL);
      w(0, 32'h5);
      w(16 + 3, 32'hFFFFFF);
      stg[3] = 24'hFFFFFF;
      push_frame(NL);
      w(0, 32'h5);
      w(0, 32'h5);
      apb_read(1, rdv, err);
      check("t3_status_pending", rdv, 32'h0000_0203);
      wait_done(4, 2 * (NL + RC) + 100);
      check("t3_px3_new", px3_last, 24'hFFFFFF);
      repeat (RC + 30) @(posedge PCLK);
      #1;
      check("t3_idle_after", 32'(bus.busy), 0);
      check("t3_no_extra_frame", done_cnt, 4);
      check("t3_queue_empty", exp_q.size(), 0);

      // Auto-repeat, then abort at pixel 7
      push_frame(NL);
      push_frame(NL);
      push_frame(7);
      w(0, 32'h7);
      @(negedge PCLK); #1 b2b = 1;
      wait_done(6, 2 * (NL + RC) + 100);
      ready_mode = 2;
      n = 0;
      while (!(bus.pix_valid && frame_pos == 7) && n < 200) begin
         @(negedge PCLK); #1;
         n++;
      end
      check("t4_reach_idx7", frame_pos, 7);
      w(0, 32'h0);
      @(negedge PCLK); #1;
      check("t4_abort_valid", 32'(bus.pix_valid), 0);
      check("t4_abort_busy", 32'(bus.busy), 1);
      b2b = 0;
      repeat (RC + 5) @(posedge PCLK);
      #1;
      check("t4_idle", 32'(bus.busy), 0);
      check("t4_no_done", done_cnt, 6);
      check("t4_queue_empty", exp_q.size(), 0);
      ready_mode = 0;

      // Unmapped offsets and read-only STATUS
      apb_read(2, rdv, err);
      check("t5_rd02_data", rdv, 32'h0);
      check("t5_rd02_err", 32'(err), 1);
      apb_write(16'h1F, 32'h123456, err);
      check("t5_wr1f_err", 32'(err), 1);
      apb_read(16'h1F, rdv, err);
      check("t5_rd1f_data", rdv, 32'h0);
      apb_write(1, 32'hFFFF, err);
      check("t5_status_wr_noerr", 32'(err), 0);
      apb_read(1, rdv, err);
      check("t5_status_unchanged", rdv, 32'h0000_0600);
      apb_read(0, rdv, err);
      check("t5_ctrl", rdv, 32'h0);
      apb_read(16 + 14, rdv, err);
      check("t5_pixel14", rdv, 32'h0001_000E);
      apb_write(16, 32'hAB12_3456, err);
      stg[0] = 24'h123456;
      check("t5_pix_wr_noerr", 32'(err), 0);
      apb_read(16, rdv, err);
      check("t5_pixel0_top_zero", rdv, 32'h0012_3456);

      // Asynchronous reset mid-frame
      ready_mode = 3;
      w(0, 32'h5);
      n = 0;
      while (!bus.pix_valid && n < 20) begin
         @(negedge PCLK);
         n++;
      end
      check("t6_sending", 32'(bus.pix_valid), 1);
      #2 PRESET = 1'b1;
      #1;
      check("t6_rst_valid", 32'(bus.pix_valid), 0);
      check("t6_rst_busy", 32'(bus.busy), 0);
      check("t6_rst_data", bus.pix_data, 0);
      exp_q.delete();
      for (int i = 0; i < NL; i++) stg[i] = '0;
      repeat (2) @(posedge PCLK);
      #1 PRESET = 1'b0;
      ready_mode = 0;
      apb_read(1, rdv, err);
      check("t6_status", rdv, 32'h0);
      apb_read(0, rdv, err);
      check("t6_ctrl", rdv, 32'h0);
      apb_read(16 + 3, rdv, err);
      check("t6_pixel3", rdv, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
